// File: rtl/finish_line_fsm.sv
// Reaction-timer responder: measures lights-out to key press in ms as packed BCD,
// flags false starts and no-response. Optional best-time register under BEST_TIME_EN.
module finish_line_fsm #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] MAX_BCD     = 16'h9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_ms,
  input  logic        arm,
  input  logic        go,
  input  logic        trigger,
  output logic [15:0] result_bcd,
  output logic        busy,
  output logic        done,
  output logic        false_start,
  output logic        no_response,
  output logic [15:0] best_bcd
);

  localparam int unsigned BCD_W  = 16;
  localparam int unsigned DIGITS = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_TIMING  = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_FALSE   = 3'd4;
  localparam logic [2:0] S_TIMEOUT = 3'd5;

  // Decimal increment with ripple carry across all four nibbles
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_d;
  logic                   synced;
  logic                   press;

  logic [2:0]       state, state_nxt;
  logic [BCD_W-1:0] result_nxt;
  logic             busy_nxt, done_nxt, false_nxt, nores_nxt;

  // Key synchroniser; released level is 1 so reset never fabricates a press
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      key_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trigger};
      key_d  <= synced;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign press  = key_d & ~synced;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      result_bcd  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      false_start <= 1'b0;
      no_response <= 1'b0;
    end else begin
      state       <= state_nxt;
      result_bcd  <= result_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      false_start <= false_nxt;
      no_response <= nores_nxt;
    end
  end

  // arm outranks everything; within ARMED/TIMING a press outranks go/tick
  always_comb begin
    state_nxt  = state;
    result_nxt = result_bcd;
    false_nxt  = false_start;
    nores_nxt  = no_response;
    done_nxt   = 1'b0;
    if (arm) begin
      state_nxt  = S_ARMED;
      result_nxt = '0;
      false_nxt  = 1'b0;
      nores_nxt  = 1'b0;
    end else begin
      case (state)
        S_ARMED: begin
          if (press) begin
            state_nxt = S_FALSE;
            false_nxt = 1'b1;
          end else if (go) begin
            state_nxt  = S_TIMING;
            result_nxt = '0;
          end
        end
        S_TIMING: begin
          if (press) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else if (tick_ms) begin
            if (result_bcd == MAX_BCD) begin
              state_nxt = S_TIMEOUT;
              nores_nxt = 1'b1;
            end else begin
              result_nxt = bcd_inc(result_bcd);
            end
          end
        end
        default: ;
      endcase
    end
    busy_nxt = (state_nxt == S_ARMED) || (state_nxt == S_TIMING);
  end

`ifdef BEST_TIME_EN
  logic [BCD_W-1:0] best_q;
  logic             capture;

  // Packed BCD orders the same as unsigned binary, so a plain compare suffices
  assign capture = !arm && (state == S_TIMING) && press;

  always_ff @(posedge clk) begin
    if (reset) begin
      best_q <= 16'h9999;
    end else if (capture && (result_bcd < best_q)) begin
      best_q <= result_bcd;
    end
  end

  assign best_bcd = best_q;
`else
  assign best_bcd = 16'h9999;
`endif

endmodule

// File: tb/tb_finish_line_fsm.sv
// Scoreboard bench for finish_line_fsm: a decimal reference model queues expected
// capture/false-start/timeout events; a monitor compares them as the DUT reports them.
module tb_finish_line_fsm;

  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        reset, tick_ms, arm, go, trigger;
  logic [15:0] result_bcd, best_bcd;
  logic        busy, done, false_start, no_response;

  finish_line_fsm #(.SYNC_STAGES(SYNC), .MAX_BCD(16'h9999)) dut (
    .clk(clk), .reset(reset), .tick_ms(tick_ms), .arm(arm), .go(go),
    .trigger(trigger), .result_bcd(result_bcd), .busy(busy), .done(done),
    .false_start(false_start), .no_response(no_response), .best_bcd(best_bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;   // 0 capture, 1 false start, 2 timeout
    int res;
    int best;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: phase 0 idle, 1 armed, 2 timing, 3 finished
  int ph     = 0;
  int cnt    = 0;
  int best_m = 9999;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind);
    exp_t e;
    e.kind = kind;
    e.res  = (kind == 2) ? 9999 : ((kind == 1) ? 0 : cnt);
    e.best = best_m;
    q.push_back(e);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    ph  = 1;
    cnt = 0;
  endtask

  task automatic do_go();
    go = 1'b1;
    step();
    go = 1'b0;
    if (ph == 1) begin
      ph  = 2;
      cnt = 0;
    end
  endtask

  task automatic do_ticks(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      tick_ms = 1'b1;
      step();
      tick_ms = 1'b0;
      if (ph == 2) begin
        if (cnt == 9999) begin
          ph = 3;
          push(2);
        end else begin
          cnt++;
        end
      end
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step();
    end
  endtask

  // Key goes low; the press acts SYNC+1 edges later, optionally with tick/go on that edge
  task automatic press_key(input logic with_tick, input logic with_go);
    trigger = 1'b0;
    repeat (SYNC) step();
    tick_ms = with_tick;
    go      = with_go;
    step();
    tick_ms = 1'b0;
    go      = 1'b0;
    if (ph == 1) begin
      ph = 3;
      push(1);
    end else if (ph == 2) begin
      ph = 3;
`ifdef BEST_TIME_EN
      if (cnt < best_m) best_m = cnt;
`endif
      push(0);
    end
    repeat (2) step();
    trigger = 1'b1;
    repeat (SYNC + 2) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset  = 1'b0;
    ph     = 0;
    cnt    = 0;
    best_m = 9999;
  endtask

  task automatic chk_reset_vals();
    chk("rst_result", int'(result_bcd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_false", int'(false_start), 0);
    chk("rst_nores", int'(no_response), 0);
    chk("rst_best", int'(best_bcd), 16'h9999);
  endtask

  // Monitor: pop and compare whenever the DUT reports an outcome
  logic done_p = 1'b0, fs_p = 1'b0, nr_p = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      int kind;
      kind = -1;
      if (done) kind = 0;
      else if (false_start && !fs_p) kind = 1;
      else if (no_response && !nr_p) kind = 2;
      if (done && done_p) chk("done_width", 2, 1);
      if (kind >= 0) begin
        if (q.size() == 0) begin
          chk("unexpected_event", kind, -1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_result", int'(result_bcd), int'(to_bcd(e.res)));
          chk("event_busy", int'(busy), 0);
          chk("event_best", int'(best_bcd), int'(to_bcd(e.best)));
        end
      end
    end
    done_p <= done;
    fs_p   <= false_start;
    nr_p   <= no_response;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; tick_ms = 1'b0; arm = 1'b0; go = 1'b0; trigger = 1'b1;
    repeat (3) step();
    chk_reset_vals();
    reset = 1'b0;
    step();

    // Normal reaction of 237 ms
    do_arm();
    chk("armed_busy", int'(busy), 1);
    do_go();
    do_ticks(237, 1);
    chk("cnt_237", int'(result_bcd), int'(to_bcd(cnt)));
    press_key(1'b0, 1'b0);
    chk("after_done_busy", int'(busy), 0);
    chk("after_done_hold", int'(result_bcd), 16'h0237);

    // False start; later go ignored, next arm clears
    do_arm();
    repeat (3) step();
    press_key(1'b0, 1'b0);
    do_go();
    step();
    chk("fs_go_ignored_busy", int'(busy), 0);
    chk("fs_level", int'(false_start), 1);
    do_arm();
    chk("fs_cleared", int'(false_start), 0);

    // Carry and saturation
    do_go();
    do_ticks(999, 0);
    chk("cnt_0999", int'(result_bcd), 16'h0999);
    do_ticks(1, 0);
    chk("cnt_1000", int'(result_bcd), 16'h1000);
    do_ticks(8999, 0);
    chk("cnt_9999", int'(result_bcd), 16'h9999);
    chk("cnt_9999_busy", int'(busy), 1);
    do_ticks(1, 0);
    step();
    chk("timeout_level", int'(no_response), 1);
    do_ticks(2, 0);
    chk("timeout_hold", int'(result_bcd), 16'h9999);
    do_arm();
    chk("nores_cleared", int'(no_response), 0);
    chk("arm_clears_result", int'(result_bcd), 0);

    // Press and tick on the same edge at 0041
    do_go();
    do_ticks(41, 1);
    press_key(1'b1, 1'b0);

    // Press and go on the same edge in ARMED
    do_arm();
    press_key(1'b0, 1'b1);

    // arm during TIMING restarts
    do_arm();
    do_go();
    do_ticks(17, 0);
    do_arm();
    chk("restart_result", int'(result_bcd), 0);
    chk("restart_busy", int'(busy), 1);
    do_go();
    do_ticks(5, 0);
    press_key(1'b0, 1'b0);

    // Reset mid-TIMING at 0150 with key held through it
    do_arm();
    do_go();
    do_ticks(150, 0);
    chk("cnt_0150", int'(result_bcd), 16'h0150);
    trigger = 1'b0;
    do_reset();
    chk_reset_vals();
    repeat (6) step();
    do_arm();
    do_go();
    do_ticks(5, 0);
    repeat (4) step();
    chk("held_no_press_busy", int'(busy), 1);
    chk("held_no_press_cnt", int'(result_bcd), 16'h0005);
    trigger = 1'b1;
    repeat (SYNC + 2) step();
    press_key(1'b0, 1'b0);

    // Best-time sequence from a fresh reset
    do_reset();
    step();
    do_arm(); do_go(); do_ticks(300, 0); press_key(1'b0, 1'b0);
    do_arm(); do_go(); do_ticks(250, 0); press_key(1'b0, 1'b0);
    do_arm(); do_go(); do_ticks(410, 0); press_key(1'b0, 1'b0);
    do_arm(); press_key(1'b0, 1'b0);
    chk("best_after_seq", int'(best_bcd), int'(to_bcd(best_m)));

    // Randomised runs
    for (int r = 0; r < 25; r++) begin
      do_arm();
      repeat ($urandom_range(0, 3)) step();
      if ($urandom_range(0, 3) == 0) begin
        press_key(1'b0, 1'($urandom_range(0, 1)));
      end else begin
        do_go();
        do_ticks($urandom_range(0, 300), 2);
        if ($urandom_range(0, 5) == 0) begin
          do_arm();
          do_go();
          do_ticks($urandom_range(0, 100), 1);
        end
        press_key(1'($urandom_range(0, 1)), 1'b0);
      end
      chk("rand_best", int'(best_bcd), int'(to_bcd(best_m)));
    end

    repeat (4) step();
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/finish_line_fsm.md
Name: finish_line_fsm

Overview:
- Responder end of the reaction-timer start protocol. The starting-line sequencer lights the LEDs and then waits a random delay. This block measures the player's reaction from "lights out" to key press, in milliseconds, as 4-digit packed BCD.
- Detects false starts (a press before lights out) and no-response (the counter saturates).
- Sits between the start sequencer and the 7-segment display driver.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages synchronising the key input (minimum 2).
- MAX_BCD, 16'h9999, saturation/timeout value of the reaction counter (packed BCD, each nibble 0-9).

Ports:
- clk  input  1  system clock (50 MHz)
- reset  input  1  synchronous, active-high reset
- tick_ms  input  1  one-clk pulse every 1 ms, from the shared tick divider
- arm  input  1  one-clk pulse when the start sequence begins (first LED lit)
- go  input  1  one-clk pulse when the LEDs clear (lights out)
- trigger  input  1  player key, active-low, asynchronous
- result_bcd  output  16  reaction time in ms, packed BCD [15:12] thousands … [3:0] units
- busy  output  1  high in ARMED or TIMING
- done  output  1  one-clk pulse on a valid reaction capture
- false_start  output  1  level; press occurred before go
- no_response  output  1  level; counter reached MAX_BCD
- best_bcd  output  16  best valid time since reset (see Optional Feature)

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high.
  - reset forces: state=IDLE, result_bcd=0, busy=0, done=0, false_start=0, no_response=0, best_bcd=16'h9999.
  - Reset asserted mid-operation aborts immediately, with no result.
- Key input:
  - trigger passes through SYNC_STAGES flip-flops, reset to 1 (released).
  - press = synced value falls 1→0 (one-clk pulse). Holding the key yields a single press.
  - Press latency: SYNC_STAGES+1 clks from the pin edge.
- State machine (one-hot or binary, implementer's choice):
  - IDLE: busy=0. arm → ARMED; same edge clears result_bcd, false_start and no_response.
  - ARMED: busy=1.
    - press → FALSE; false_start=1 on the next clk.
    - go → TIMING; result_bcd=0.
    - press and go in the same clk → FALSE (the press wins).
  - TIMING: busy=1.
    - Each tick_ms increments result_bcd by 1 in BCD: units 9→0 carries into tens, and so on, ripple within one clk.
    - press → DONE; result_bcd frozen; done=1 for exactly one clk.
    - press and tick_ms in the same clk → the press wins; that tick is not counted.
    - tick_ms while result_bcd==MAX_BCD → TIMEOUT; no_response=1; result_bcd holds MAX_BCD.
  - DONE, FALSE, TIMEOUT: busy=0. Outputs hold until the next arm.
- Restarting:
  - arm in any state, including ARMED and TIMING, restarts into ARMED with the same clears as IDLE→ARMED.
  - arm outranks press, go and tick_ms in the same clk.
- Ignored inputs: go outside ARMED and tick_ms outside TIMING are ignored.
- Width rule: all nibbles are always 0-9. No binary-to-BCD conversion anywhere.

Optional Feature:
- Macro BEST_TIME_EN.
- Defined:
  - On each DONE entry, if the captured result_bcd < best_bcd, then best_bcd ← result_bcd.
  - The compare is an unsigned 16-bit compare, which is valid for packed BCD.
  - FALSE and TIMEOUT never update best_bcd.
  - best_bcd is cleared to 16'h9999 only by reset.
- Undefined:
  - No best register is synthesised.
  - best_bcd is tied to constant 16'h9999.
  - The port list is identical in both builds.

Test Plan:
- Normal reaction: reset; arm; go; 237 tick_ms pulses; key low → result_bcd=16'h0237, done pulses 1 clk, busy=0, false_start=0.
- False start: arm; key low before go → false_start=1, busy=0, done never asserts. A later go is ignored. The next arm clears false_start.
- BCD carry and saturation: arm; go; 999 ticks → 16'h0999. 1 more tick → 16'h1000. Run to 9999 then one more tick → no_response=1, result_bcd=16'h9999.
- Simultaneous events:
  - press and tick_ms same clk at count 16'h0041 → result 16'h0041.
  - press and go same clk in ARMED → FALSE.
  - arm during TIMING → ARMED, result_bcd=0.
- Reset mid-TIMING at 16'h0150 → all outputs return to reset values the next clk. Holding the key through the reset and a subsequent arm/go gives no press until release and re-press.
- BEST_TIME_EN defined:
  - Valid runs of 0300, 0250, 0410, then a false start → best_bcd=16'h0250.
  - Macro undefined → best_bcd=16'h9999 throughout.
